// File: rtl/f2i_convert_scheduler.sv
// Round-robin scheduler that time-shares one fp16->int16 converter between NUM_REQ requesters,
// streaming NUM_COMP components per request and saturating out-of-range operands.
module f2i_convert_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_COMP = 3,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic [NUM_REQ-1:0]                      req_valid_in,
  input  logic [NUM_REQ-1:0][NUM_COMP*16-1:0]     req_data_in,
  output logic [NUM_REQ-1:0]                      req_ready_out,
  output logic [15:0]                             conv_f_out,
  input  logic [15:0]                             conv_int_in,
  output logic                                    res_valid_out,
  input  logic                                    res_ready_in,
  output logic [IW-1:0]                           res_id_out,
  output logic [NUM_COMP*16-1:0]                  res_data_out,
  output logic [NUM_COMP-1:0]                     res_ovf_out
);

  typedef enum logic [1:0] {IDLE, CONVERT, RESULT} state_t;

  state_t                     state, state_nxt;
  logic [IW-1:0]              rr_ptr, gnt_id, gnt;
  logic                       gnt_vld;
  logic [IW:0]                idx;
  logic [CW-1:0]              comp_idx;
  logic [NUM_COMP-1:0][15:0]  lat, res_data;
  logic [NUM_COMP-1:0]        res_ovf;
  logic                       sat;
  logic [15:0]                slot;
  logic                       last_comp;

  // Lowest offset from rr_ptr wins, so scan offsets from high to low and let the last hit stick.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (req_valid_in[idx[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[IW-1:0];
      end
    end
  end

  assign last_comp = (comp_idx == CW'(NUM_COMP-1));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready_out = '0;
    conv_f_out    = '0;
    res_valid_out = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld) begin
          req_ready_out[gnt] = 1'b1;
          state_nxt          = CONVERT;
        end
      end
      CONVERT: begin
        conv_f_out = lat[comp_idx];
        if (last_comp) state_nxt = RESULT;
      end
      RESULT: begin
        res_valid_out = 1'b1;
        if (res_ready_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturation is judged on the operand exponent; the converter output is ignored when saturating.
  assign sat  = (conv_f_out[14:10] >= 5'd30);
  assign slot = sat ? (conv_f_out[15] ? 16'h8000 : 16'h7FFF) : conv_int_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr   <= '0;
      gnt_id   <= '0;
      comp_idx <= '0;
      lat      <= '0;
      res_data <= '0;
      res_ovf  <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          lat      <= req_data_in[gnt];
          gnt_id   <= gnt;
          comp_idx <= '0;
        end
        CONVERT: begin
          res_data[comp_idx] <= slot;
          res_ovf[comp_idx]  <= sat;
          comp_idx           <= last_comp ? '0 : comp_idx + 1'b1;
        end
        RESULT: if (res_ready_in)
          rr_ptr <= (gnt_id == IW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        default: ;
      endcase
    end
  end

  assign res_id_out   = gnt_id;
  assign res_data_out = res_data;
  assign res_ovf_out  = res_ovf;

endmodule

// File: tb/tb_f2i_convert_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grants and results; a negedge monitor compares.
module tb_f2i_convert_scheduler;
  localparam int NR = 4;
  localparam int NC = 3;
  localparam int IW = $clog2(NR);

  logic                      clk = 1'b0;
  logic                      rst_in = 1'b1;
  logic [NR-1:0]             req_valid_in = '0;
  logic [NR-1:0][NC*16-1:0]  req_data_in = '0;
  logic [NR-1:0]             req_ready_out;
  logic [15:0]               conv_f_out, conv_int_in;
  logic                      res_valid_out;
  logic                      res_ready_in = 1'b1;
  logic [IW-1:0]             res_id_out;
  logic [NC*16-1:0]          res_data_out;
  logic [NC-1:0]             res_ovf_out;

  f2i_convert_scheduler #(.NUM_REQ(NR), .NUM_COMP(NC)) dut (
    .clk_in(clk), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out), .conv_f_out(conv_f_out), .conv_int_in(conv_int_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in), .res_id_out(res_id_out),
    .res_data_out(res_data_out), .res_ovf_out(res_ovf_out));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Stand-in converter: truncate toward zero; out-of-range operands return junk on purpose.
  function automatic logic [15:0] f2i_trunc(input logic [15:0] f);
    int e, mag;
    e = int'(f[14:10]);
    if (e == 0) return 16'h0000;
    if (e >= 30) return 16'h5A5A;
    mag = 1024 + int'(f[9:0]);
    mag = (e >= 25) ? (mag << (e - 25)) : (mag >> (25 - e));
    if (f[15]) mag = -mag;
    return mag[15:0];
  endfunction

  always_comb conv_int_in = f2i_trunc(conv_f_out);

  typedef struct {
    logic [IW-1:0]    id;
    logic [NC*16-1:0] data;
    logic [NC-1:0]    ovf;
  } exp_t;

  function automatic exp_t predict(input int id, input logic [NC*16-1:0] d);
    exp_t x;
    logic [15:0] f;
    x.id = IW'(id);
    for (int k = 0; k < NC; k++) begin
      f = d[16*k +: 16];
      if (f[14:10] >= 5'd30) begin
        x.data[16*k +: 16] = f[15] ? 16'h8000 : 16'h7FFF;
        x.ovf[k] = 1'b1;
      end else begin
        x.data[16*k +: 16] = f2i_trunc(f);
        x.ovf[k] = 1'b0;
      end
    end
    return x;
  endfunction

  // Reference model state
  exp_t                exp_q[$];
  bit                  m_busy = 0;
  int                  m_rr = 0, m_acc = 0, cyc = 0, mk, mg;
  bit                  busy0;
  logic [NC-1:0][15:0] m_lat;
  logic [NR-1:0]       exp_ready, acc_mask = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst_in) begin
      m_busy = 0; m_rr = 0; exp_q.delete(); acc_mask = '0;
    end else begin
      busy0 = m_busy;
      if (m_busy) begin
        mk = cyc - m_acc - 1;
        if (mk < NC) chk("conv_f", 64'(conv_f_out), 64'(m_lat[mk]));
        chk("res_valid", 64'(res_valid_out), 64'(mk >= NC));
        if (res_valid_out && mk >= NC && exp_q.size() > 0) begin
          chk("res_id", 64'(res_id_out), 64'(exp_q[0].id));
          chk("res_data", 64'(res_data_out), 64'(exp_q[0].data));
          chk("res_ovf", 64'(res_ovf_out), 64'(exp_q[0].ovf));
          if (res_ready_in) begin
            m_rr = (int'(exp_q[0].id) + 1) % NR;
            m_busy = 0;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("res_valid_idle", 64'(res_valid_out), 64'(0));
      end
      exp_ready = '0;
      if (!busy0 && |req_valid_in) begin
        mg = -1;
        for (int o = 0; o < NR; o++)
          if (mg < 0 && req_valid_in[(m_rr + o) % NR]) mg = (m_rr + o) % NR;
        exp_ready[mg] = 1'b1;
        exp_q.push_back(predict(mg, req_data_in[mg]));
        m_lat = req_data_in[mg];
        m_busy = 1;
        m_acc = cyc;
      end
      chk("req_ready", 64'(req_ready_out), 64'(exp_ready));
      if (!busy0 && !(|req_valid_in)) chk("conv_f_idle", 64'(conv_f_out), 64'(0));
      acc_mask = req_valid_in & req_ready_out;
    end
  end

  // Driver
  int mode = 0;           // 0 directed, 1 random, 2 all requesters saturated
  bit rec_grants = 0;
  int grants[$];
  logic [15:0] specials [8] = '{16'h7C00, 16'hFC00, 16'h7800, 16'hF800,
                                16'h7BFF, 16'h0001, 16'h8000, 16'h77FF};

  function automatic logic [NC*16-1:0] rnd_vec();
    logic [NC*16-1:0] v;
    logic [31:0] r;
    for (int k = 0; k < NC; k++) begin
      r = $urandom();
      v[16*k +: 16] = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : r[15:0];
    end
    return v;
  endfunction

  task automatic tick();
    logic [31:0] junk;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) if (acc_mask[i]) begin
      if (rec_grants) grants.push_back(i);
      req_valid_in[i] = 1'b0;
      junk = $urandom();
      req_data_in[i] = {NC{junk[15:0]}};
    end
    for (int i = 0; i < NR; i++)
      if (!req_valid_in[i] && (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1))) begin
        req_data_in[i] = rnd_vec();
        req_valid_in[i] = 1'b1;
      end
    if (mode == 1) res_ready_in = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int id, input logic [NC*16-1:0] d);
    int n = 0;
    req_data_in[id] = d;
    req_valid_in[id] = 1'b1;
    while (req_valid_in[id] && n < 200) begin tick(); n++; end
    if (req_valid_in[id]) begin failures++; $display("FAIL send_timeout: req %0d never accepted", id); end
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid_out && n < 50) begin tick(); n++; end
    if (!res_valid_out) begin failures++; $display("FAIL res_timeout: no result after %0d cycles", n); end
  endtask

  task automatic chk_reset_outs();
    chk("rst_res_valid", 64'(res_valid_out), 64'(0));
    chk("rst_res_data", 64'(res_data_out), 64'(0));
    chk("rst_res_ovf", 64'(res_ovf_out), 64'(0));
    chk("rst_res_id", 64'(res_id_out), 64'(0));
    chk("rst_req_ready", 64'(req_ready_out), 64'(0));
    chk("rst_conv_f", 64'(conv_f_out), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NC*16-1:0] hold_d;
    logic [NC-1:0]    hold_o;
    logic [IW-1:0]    hold_i;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    repeat (3) tick();
    rst_in = 1'b0;
    chk_reset_outs();

    // Basic conversion and latency
    send(0, {16'h5640, 16'h3E00, 16'hC000});
    wait_res(n);
    chk("t1_latency", 64'(n), 64'(NC));
    chk("t1_data", 64'(res_data_out), 64'({16'h0064, 16'h0001, 16'hFFFE}));
    chk("t1_ovf", 64'(res_ovf_out), 64'(0));
    chk("t1_id", 64'(res_id_out), 64'(0));
    tick();

    // Infinities and out-of-range saturate
    send(1, {16'h7800, 16'hFC00, 16'h7C00});
    wait_res(n);
    chk("t2_data", 64'(res_data_out), 64'({16'h7FFF, 16'h8000, 16'h7FFF}));
    chk("t2_ovf", 64'(res_ovf_out), 64'(3'b111));
    chk("t2_id", 64'(res_id_out), 64'(1));
    tick();

    // Subnormal and signed zero
    send(2, {16'h0000, 16'h8000, 16'h0001});
    wait_res(n);
    chk("t5_data", 64'(res_data_out), 64'(0));
    chk("t5_ovf", 64'(res_ovf_out), 64'(0));
    tick();

    // Backpressure: result held, no grants while waiting
    res_ready_in = 1'b0;
    send(2, {16'h4A00, 16'hBC00, 16'h7A00});
    req_data_in[0] = {16'h3C00, 16'h3C00, 16'h3C00};
    req_valid_in[0] = 1'b1;
    wait_res(n);
    hold_d = res_data_out; hold_o = res_ovf_out; hold_i = res_id_out;
    chk("t4_id", 64'(hold_i), 64'(2));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_data", 64'(res_data_out), 64'(hold_d));
      chk("t4_hold_ovf", 64'(res_ovf_out), 64'(hold_o));
      chk("t4_hold_valid", 64'(res_valid_out), 64'(1));
      chk("t4_no_ready", 64'(req_ready_out), 64'(0));
    end
    res_ready_in = 1'b1;
    tick();
    chk("t4_idle_valid", 64'(res_valid_out), 64'(0));
    chk("t4_idle_grant", 64'(req_ready_out), 64'(4'b0001));
    repeat (10) tick();

    // Round-robin rotation with every requester asserted
    send(3, {16'h3C00, 16'h3C00, 16'h3C00});
    repeat (8) tick();
    rec_grants = 1; mode = 2;
    repeat (25) tick();
    mode = 0;
    repeat (40) tick();
    rec_grants = 0;
    if (grants.size() < 5) begin failures++; $display("FAIL t3_grants: got %0d grants need 5", grants.size()); end
    else for (int i = 0; i < 5; i++) chk("t3_rr_order", 64'(grants[i]), 64'(exp_order[i]));

    // Reset mid-CONVERT: discard in flight, pointer back to 0
    send(1, {16'h3C00, 16'h4000, 16'h4200});
    repeat (8) tick();
    send(3, {16'h4400, 16'h4500, 16'h4600});
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk_reset_outs();
    repeat (8) tick();
    req_data_in[1] = {16'h4000, 16'h4000, 16'h4000};
    req_data_in[2] = {16'hC200, 16'hC200, 16'hC200};
    req_valid_in[1] = 1'b1;
    req_valid_in[2] = 1'b1;
    wait_res(n);
    chk("t6_first_id", 64'(res_id_out), 64'(1));
    tick();
    wait_res(n);
    chk("t6_second_id", 64'(res_id_out), 64'(2));
    chk("t6_second_data", 64'(res_data_out), 64'({16'hFFFD, 16'hFFFD, 16'hFFFD}));
    tick();

    // Random traffic
    mode = 1;
    repeat (3000) tick();
    mode = 0;
    res_ready_in = 1'b1;
    n = 0;
    while ((|req_valid_in || res_valid_out || m_busy) && n < 200) begin tick(); n++; end
    if (|req_valid_in || m_busy) begin failures++; $display("FAIL drain_timeout: traffic did not drain"); end
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
